// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared definitions for the instruction fetch queue.
//   fetchState_e      fetch FSM state encoding (IDLE/REQ/DROP)
//   RESET_PC_DEFAULT  default fetch address after reset
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH FIFO holding fetched {instruction, pc} entries.
//   clk, rst        clock, asynchronous active-high reset
//   push, wrData    write an entry (ignored when full unless popping too)
//   pop             remove the head (ignored when empty)
//   flush           empty the FIFO; overrides push and pop in that cycle
//   rdData          head entry, zero when empty
//   full, empty     occupancy flags
//   count           number of stored entries
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wrData,
  output logic [WIDTH-1:0]           rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wrPtr, rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count  = wrPtr - rdPtr;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Issues word reads to instruction memory
// over a req/ack handshake, queues returned instructions with their PC, and
// hands them to decode with valid/ready. A redirect flushes and restarts fetch.
// Optional build macro FETCH_STATS_EN adds fetch_cnt/flush_cnt statistics ports.
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      read request and word address (held until ack)
//   imem_ack, imem_rdata     response strobe and instruction word
//   inst_valid/ready         decode handshake on the queue head
//   inst_data, inst_pc       head instruction and its PC (zero when empty)
//   redirect_valid/pc        flush strobe and new fetch address
//   fetch_cnt, flush_cnt     (FETCH_STATS_EN) pushed acks / redirect strobes
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       flush_cnt,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetchState_e              state;
  logic [ADDR_W-1:0]        fetchPc, pcNext;
  logic                     push, pop, full, empty, spaceAfter;
  logic [CW-1:0]            count, countAfter;
  logic [DATA_W+ADDR_W-1:0] headEntry;

  assign pcNext     = fetchPc + ADDR_W'(1);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign push       = (state == REQ) && imem_ack && !redirect_valid;
  // Occupancy after this cycle's push, allowing for a same-cycle pop.
  assign countAfter = count + CW'(1) - CW'(pop);
  assign spaceAfter = countAfter < CW'(DEPTH);

  assign inst_valid = !empty;
  assign inst_data  = headEntry[DATA_W+ADDR_W-1:ADDR_W];
  assign inst_pc    = headEntry[ADDR_W-1:0];

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W + ADDR_W)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wrData ({imem_rdata, fetchPc}),
    .rdData (headEntry),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetchPc   <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetchPc   <= redirect_pc;
            imem_addr <= redirect_pc;
            imem_req  <= 1'b1;
            state     <= REQ;
          end else if (!full) begin
            imem_addr <= fetchPc;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetchPc <= redirect_pc;
            if (imem_ack) begin
              imem_addr <= redirect_pc;
            end else begin
              // Request already on the bus: keep it up until its ack is drained.
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetchPc   <= pcNext;
            imem_addr <= pcNext;
            if (!spaceAfter) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_valid) fetchPc <= redirect_pc;
          if (imem_ack) begin
            imem_addr <= redirect_valid ? redirect_pc : fetchPc;
            state     <= REQ;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != '1))      fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int unsigned vectors;
  int unsigned miscompares;
  logic        autoMem;
  logic        prevReq;
  logic        prevAck;

  fetch_queue #(
    .DEPTH(4),
    .ADDR_W(32),
    .DATA_W(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
`ifdef FETCH_STATS_EN
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hDEAD0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are re-driven 1ns after the edge. In auto mode the
  // memory acks one cycle after it sees a request, never on consecutive cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (autoMem) begin
      imem_ack   = imem_req && prevReq && !prevAck;
      imem_rdata = imem_ack ? memWord(imem_addr) : '0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end
    prevReq = imem_req;
    prevAck = imem_ack;
  endtask

  task automatic doReset();
    rst = 1'b1;
    prevReq = 1'b0;
    prevAck = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    prevReq = 1'b0;
    prevAck = 1'b0;
  endtask

  initial begin
    int unsigned got;
    int unsigned lastCyc;
    int unsigned acks;
    bit          seenReq;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    autoMem = 1'b1;
    prevReq = 1'b0;
    prevAck = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset values
    doReset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif

    // Streaming: pc 0,1,2,3 one every 2 cycles
    inst_ready = 1'b1;
    got = 0;
    lastCyc = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (inst_valid) begin
        chk("stream_pc", inst_pc, got);
        chk("stream_data", inst_data, memWord(got));
        if (got > 0) chk("stream_gap", c - lastCyc, 2);
        lastCyc = c;
        got++;
      end
    end
    chk("stream_count", got, 4);

    // Backpressure: exactly DEPTH acks, then req drops
    inst_ready = 1'b0;
    doReset();
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (imem_ack) acks++;
    end
    chk("bp_acks", acks, 4);
    chk("bp_req_low", imem_req, 0);
    chk("bp_valid", inst_valid, 1);
    chk("bp_head_pc", inst_pc, 0);

    // Release: drain 0..3 and fetch resumes at 4
    inst_ready = 1'b1;
    got = 0;
    seenReq = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (inst_valid) begin
        chk("drain_pc", inst_pc, got);
        chk("drain_data", inst_data, memWord(got));
        got++;
      end
      if (imem_req && !seenReq) begin
        chk("resume_addr", imem_addr, 32'h4);
        seenReq = 1'b1;
      end
      tick();
    end
    chk("drain_count", got, 5);

    // Redirect with outstanding request, ack delayed 3 cycles
    inst_ready = 1'b0;
    autoMem = 1'b0;
    doReset();
    tick();
    chk("rd_req", imem_req, 1);
    chk("rd_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, 32'h0);
    chk("drop_valid", inst_valid, 0);
    tick();
    tick();
    imem_ack = 1'b1;
    imem_rdata = memWord(32'h0);
    tick();
    chk("rd_new_addr", imem_addr, 32'h40);
    chk("rd_stale_dropped", inst_valid, 0);
    imem_ack = 1'b1;
    imem_rdata = memWord(32'h40);
    tick();
    chk("rd_first_valid", inst_valid, 1);
    chk("rd_first_pc", inst_pc, 32'h40);
    chk("rd_first_data", inst_data, memWord(32'h40));

    // Redirect coinciding with ack and pop, two entries queued
    imem_ack = 1'b1;
    imem_rdata = memWord(32'h41);
    tick();
    chk("two_head_pc", inst_pc, 32'h40);
    chk("two_addr", imem_addr, 32'h42);
`ifdef FETCH_STATS_EN
    chk("two_fetch_cnt", fetch_cnt, 2);
    chk("two_flush_cnt", flush_cnt, 1);
`endif
    imem_ack = 1'b1;
    imem_rdata = memWord(32'h42);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    inst_ready = 1'b0;
    chk("flush_valid", inst_valid, 0);
    chk("flush_data", inst_data, 0);
    chk("flush_pc", inst_pc, 0);
    chk("flush_req", imem_req, 1);
    chk("flush_addr", imem_addr, 32'h80);
`ifdef FETCH_STATS_EN
    chk("flush_fetch_cnt", fetch_cnt, 2);
    chk("flush_flush_cnt", flush_cnt, 2);
`endif
    tick();
    chk("flush_no_push", inst_valid, 0);

    // Asynchronous reset mid-request
    imem_ack = 1'b1;
    imem_rdata = memWord(32'h80);
    tick();
    chk("pre_arst_valid", inst_valid, 1);
    chk("pre_arst_pc", inst_pc, 32'h80);
    chk("pre_arst_req", imem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", inst_valid, 0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", inst_pc, 0);
    #1;
    rst = 1'b0;
`ifdef FETCH_STATS_EN
    chk("arst_fetch_cnt", fetch_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
`endif
    prevReq = 1'b0;
    prevAck = 1'b0;
    autoMem = 1'b1;
    inst_ready = 1'b1;
    seenReq = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      tick();
      if (imem_req && !seenReq) begin
        chk("restart_addr", imem_addr, 32'h0);
        seenReq = 1'b1;
      end
      if (inst_valid) begin
        chk("restart_pc", inst_pc, 32'h0);
        chk("restart_data", inst_data, memWord(32'h0));
        got++;
      end
    end
    chk("restart_seen", got, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
